fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port freeze, input, 1, stall request from the hazard detection unit.
REQ-005 SHALL have port branch_taken, input, 1, redirect from EXE; also flushes IF/ID.
REQ-006 SHALL have port branch_address, input, 32, redirect target.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32, instruction memory word address (byte address).
REQ-009 SHALL have port imem_ready, input, 1, memory completion; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction.
REQ-011 SHALL have port if_id_pc, output, 32, registered PC+4 of the held instruction.
REQ-012 SHALL have port if_id_instruction, output, 32, registered instruction to ID.
REQ-013 SHALL have port if_id_valid, output, 1, IF/ID holds a real instruction (0 = bubble).

Function
REQ-014 SHALL implement states FETCH, HOLD and DISCARD; priority rst > branch_taken > freeze.
REQ-015 SHALL drive imem_req=1 in FETCH and DISCARD, and imem_req=0 in HOLD.
REQ-016 SHALL keep imem_addr stable while imem_req=1 and imem_ready=0: pc in FETCH, the abandoned address in DISCARD.
REQ-017 FETCH, imem_ready=1, no freeze, no branch: SHALL load IF/ID with {pc+4, imem_rdata, valid=1}, set pc<=pc+4, and stay in FETCH (1 instruction/cycle at zero wait).
REQ-018 FETCH, imem_ready=1, freeze=1, no branch: SHALL capture imem_rdata and pc into a one-entry buffer, hold IF/ID and pc, and go to HOLD.
REQ-019 FETCH, imem_ready=0, no branch: SHALL hold IF/ID when freeze=1; otherwise SHALL clear if_id_valid (insert a bubble); pc unchanged.
REQ-020 HOLD, freeze=0, no branch: SHALL load IF/ID from the buffer with valid=1, set pc<=pc+4, and go to FETCH.
REQ-021 HOLD, freeze=1: SHALL hold all state.
REQ-022 branch_taken=1 in any state: SHALL set pc<=branch_address, clear if_id_valid, and discard the buffer.
REQ-023 On branch_taken, the next state SHALL be:
- DISCARD if the current state is FETCH or DISCARD and imem_ready=0 (request outstanding);
- FETCH otherwise.
REQ-024 DISCARD: SHALL drop imem_rdata when imem_ready=1 and go to FETCH; IF/ID stays invalid. A new branch_taken SHALL update pc and remain in DISCARD if still not ready.
REQ-025 Arithmetic: pc+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-026 When if_id_valid=0, if_id_pc and if_id_instruction SHALL be 0.
REQ-027 No instruction SHALL be lost or duplicated across any freeze/branch/ready combination; the IF/ID sequence SHALL equal the architectural PC sequence.

Reset
REQ-028 rst=1 SHALL force on the next edge:
- state=FETCH, pc=RESET_PC, buffer empty;
- if_id_valid=0, if_id_pc=0, if_id_instruction=0.
REQ-029 rst SHALL override freeze and branch_taken, and SHALL abandon any outstanding request without waiting for imem_ready.
REQ-030 In the first cycle after reset, imem_req SHALL be 1 with imem_addr=RESET_PC.

Verification
REQ-031 Zero-wait stream: imem_ready=1 constantly, rdata=addr^32'hA5A5_A5A5 -> IF/ID pc 4,8,12 on consecutive cycles, each valid=1 with the matching data.
REQ-032 Freeze on return: freeze=1 for 3 cycles while fetching addr 8 with ready=1 -> IF/ID holds addr-4 instruction; imem_req=0 for 2 cycles; after release, IF/ID shows pc=12 with addr-8 data, then addr 12 is fetched.
REQ-033 Wait states: ready low for 2 cycles at addr 16, freeze=0 -> 2 bubble cycles (valid=0), then pc=20 valid; imem_addr=16 stable throughout.
REQ-034 Branch during outstanding request: addr 24 pending, branch_taken with target 32'h100 -> DISCARD; the late addr-24 data is dropped; the next request is at 32'h100; IF/ID first shows pc=32'h104.
REQ-035 Branch in HOLD plus simultaneous freeze: branch_taken=1 and freeze=1 in HOLD, target 32'h200 -> buffer dropped, if_id_valid=0, fetch at 32'h200.
REQ-036 Reset mid-wait with PC wrap: rst asserted while ready=0 -> pc=RESET_PC, valid=0 next cycle. Separately, pc=32'hFFFF_FFFC fetched -> if_id_pc=0 and the next fetch is at 0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, one-entry stall buffer and
// discard of abandoned requests.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic [31:0] disc_addr;
  logic        do_load_mem;
  logic        do_load_buf;
  logic        do_bubble;
  logic        do_pc_inc;
  logic        do_capture;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    do_load_mem = 1'b0;
    do_load_buf = 1'b0;
    do_bubble   = 1'b0;
    do_pc_inc   = 1'b0;
    do_capture  = 1'b0;
    imem_req    = (state != HOLD);
    imem_addr   = (state == DISCARD) ? disc_addr : pc;

    if (branch_taken) begin
      do_bubble  = 1'b1;
      // An outstanding request must be drained before the target can be issued.
      state_next = (state != HOLD && !imem_ready) ? DISCARD : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            if (freeze) begin
              do_capture = 1'b1;
              state_next = HOLD;
            end else begin
              do_load_mem = 1'b1;
              do_pc_inc   = 1'b1;
            end
          end else if (!freeze) begin
            do_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            do_load_buf = 1'b1;
            do_pc_inc   = 1'b1;
            state_next  = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      buf_pc            <= '0;
      buf_instr         <= '0;
      disc_addr         <= '0;
      if_id_pc          <= '0;
      if_id_instruction <= '0;
      if_id_valid       <= 1'b0;
    end else begin
      if (branch_taken) begin
        pc        <= branch_address;
        buf_pc    <= '0;
        buf_instr <= '0;
        // In DISCARD the original abandoned address is still the one in flight.
        if (state == FETCH) disc_addr <= pc;
      end else if (do_pc_inc) begin
        pc <= pc + 32'd4;
      end

      if (do_capture) begin
        buf_pc    <= pc;
        buf_instr <= imem_rdata;
      end

      if (do_bubble) begin
        if_id_pc          <= '0;
        if_id_instruction <= '0;
        if_id_valid       <= 1'b0;
      end else if (do_load_mem) begin
        if_id_pc          <= pc + 32'd4;
        if_id_instruction <= imem_rdata;
        if_id_valid       <= 1'b1;
      end else if (do_load_buf) begin
        if_id_pc          <= buf_pc + 32'd4;
        if_id_instruction <= buf_instr;
        if_id_valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized stream against an
// architectural-PC scoreboard for fetch_stage.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pops = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_ready ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .branch_taken      (branch_taken),
    .branch_address    (branch_address),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid)
  );

  typedef struct {
    logic        r, f, b;
    logic [31:0] ba;
    logic        rdy;
    logic        chk_bus;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t        vecs[$];
  sb_t         exp_q[$];
  logic [31:0] gen_addr = '0;
  logic        sb_on = 1'b0;

  function automatic vec_t v(input logic r, f, b, input logic [31:0] ba, input logic rdy,
                             input logic chk_bus, e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc);
    vec_t t;
    t.r = r; t.f = f; t.b = b; t.ba = ba; t.rdy = rdy;
    t.chk_bus = chk_bus; t.e_req = e_req; t.e_addr = e_addr;
    t.e_valid = e_valid; t.e_pc = e_pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back({gen_addr + 32'd4, gen_addr ^ KEY});
      gen_addr = gen_addr + 32'd4;
    end
  endtask

  // An IF/ID entry is consumed by ID when valid at an edge with no freeze and no flush.
  task automatic sb_step();
    sb_t e;
    if (rst) begin
      exp_q.delete();
      gen_addr = RESET_PC;
      sb_on = 1'b1;
      refill();
    end else if (sb_on) begin
      if (branch_taken) begin
        exp_q.delete();
        gen_addr = branch_address;
        refill();
      end else if (if_id_valid && !freeze) begin
        e = exp_q.pop_front();
        n_pops++;
        chk($sformatf("sb_pc #%0d", n_pops), if_id_pc, e.pc);
        chk($sformatf("sb_instr #%0d", n_pops), if_id_instruction, e.instr);
        refill();
      end
    end
  endtask

  task automatic cycle(input logic r, f, b, input logic [31:0] a, input logic rd,
                       input logic chk_bus, e_req, input logic [31:0] e_addr, input int idx);
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_address = a; imem_ready = rd;
    #1;
    if (chk_bus) begin
      chk($sformatf("imem_req v%0d", idx), {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk($sformatf("imem_addr v%0d", idx), imem_addr, e_addr);
    end
    sb_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        rf, rb, rr;
    logic [31:0] ra;
    logic [31:0] e_instr;

    // rst frz br  ba            rdy  chk req addr           valid pc
    vecs.push_back(v(1,0,0,32'h0,0,          0,0,32'h0,          0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h0,          1,32'h4));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h4,          1,32'h8));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h8,          1,32'hC));
    vecs.push_back(v(1,0,0,32'h0,0,          1,1,32'hC,          0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h0,          1,32'h4));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h4,          1,32'h8));
    vecs.push_back(v(0,1,0,32'h0,1,          1,1,32'h8,          1,32'h8));
    vecs.push_back(v(0,1,0,32'h0,0,          1,0,32'h8,          1,32'h8));
    vecs.push_back(v(0,1,0,32'h0,0,          1,0,32'h8,          1,32'h8));
    vecs.push_back(v(0,0,0,32'h0,0,          1,0,32'h8,          1,32'hC));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'hC,          1,32'h10));
    vecs.push_back(v(0,0,0,32'h0,0,          1,1,32'h10,         0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,0,          1,1,32'h10,         0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h10,         1,32'h14));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h14,         1,32'h18));
    vecs.push_back(v(0,0,1,32'h100,0,        1,1,32'h18,         0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,0,          1,1,32'h18,         0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h18,         0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h100,        1,32'h104));
    vecs.push_back(v(0,1,0,32'h0,1,          1,1,32'h104,        1,32'h104));
    vecs.push_back(v(0,1,1,32'h200,0,        1,0,32'h0,          0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h200,        1,32'h204));
    vecs.push_back(v(0,0,0,32'h0,0,          1,1,32'h204,        0,32'h0));
    vecs.push_back(v(1,0,0,32'h0,0,          1,1,32'h204,        0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,RESET_PC,       1,RESET_PC + 32'h4));
    vecs.push_back(v(0,0,1,32'hFFFF_FFFC,1,  1,1,32'h4,          0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'hFFFF_FFFC,  1,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h0,          1,32'h4));
    vecs.push_back(v(0,0,1,32'h300,0,        1,1,32'h4,          0,32'h0));
    vecs.push_back(v(0,0,1,32'h400,0,        1,1,32'h4,          0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h4,          0,32'h0));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h400,        1,32'h404));
    vecs.push_back(v(0,1,0,32'h0,0,          1,1,32'h404,        1,32'h404));
    vecs.push_back(v(0,0,0,32'h0,1,          1,1,32'h404,        1,32'h408));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].ba, vecs[i].rdy,
            vecs[i].chk_bus, vecs[i].e_req, vecs[i].e_addr, i);
      e_instr = vecs[i].e_valid ? ((vecs[i].e_pc - 32'd4) ^ KEY) : 32'h0;
      chk($sformatf("if_id_valid v%0d", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("if_id_pc v%0d", i), if_id_pc, vecs[i].e_pc);
      chk($sformatf("if_id_instr v%0d", i), if_id_instruction, e_instr);
    end

    // Randomized freeze/branch/wait-state mix; the scoreboard checks ordering.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, -1);
    n_pops = 0;
    for (int i = 0; i < 600; i++) begin
      rf = ($urandom_range(0, 9) < 3);
      rb = ($urandom_range(0, 99) < 6);
      ra = {$urandom_range(0, 32'h3FFF), 2'b00};
      rr = imem_req && ($urandom_range(0, 9) < 7);
      cycle(1'b0, rf, rb, ra, rr, 1'b0, 1'b0, 32'h0, i);
      if (!if_id_valid) begin
        chk($sformatf("bubble_pc r%0d", i), if_id_pc, 32'h0);
        chk($sformatf("bubble_instr r%0d", i), if_id_instruction, 32'h0);
      end
    end
    n_chk++;
    if (n_pops < 100) begin
      n_fail++;
      $display("FAIL sb_progress: got %0d consumed expected at least 100", n_pops);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
